// File: rtl/parity_serial_rx.sv
`timescale 1ns/1ps
// Serial frame receiver: start bit, DATA_W data bits (LSB first), parity bit, stop bit.
// Delivers the recovered word with its received parity bit, parity/framing error flags,
// and keeps a saturating count of frames that carried a parity error.
module parity_serial_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              bit_en_in,
    input  logic              serial_in,
    input  logic              clr_cnt_in,
    output logic [DATA_W-1:0] data_out,
    output logic              p_out,
    output logic              valid_out,
    output logic              parity_err_out,
    output logic              frame_err_out,
    output logic              busy_out,
    output logic [7:0]        err_cnt_out
);

    // Keep the counter at least one bit wide so DATA_W=1 still elaborates.
    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                p_q, p_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    // Frame FSM: advances one step per qualified line bit; disabled cycles hold everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        p_d     = p_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        if (bit_en_in) begin
            unique case (state_q)
                StIdle: begin
                    if (!serial_in) begin
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = StData;
                    end
                end
                StData: begin
                    shift_d[cnt_q] = serial_in;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = serial_in;
                    state_d = StStop;
                end
                StStop: begin
                    data_d  = shift_q;
                    p_d     = par_q;
                    perr_d  = (^shift_q) ^ par_q ^ PARITY_ODD;
                    ferr_d  = ~serial_in;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    // Error counter works off the registered flags, so it lags valid_out by one cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt_in) begin
            err_cnt_d = 8'd0;
        end else if (valid_q && perr_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            p_q       <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            p_q       <= p_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_out       = data_q;
    assign p_out          = p_q;
    assign valid_out      = valid_q;
    assign parity_err_out = perr_q;
    assign frame_err_out  = ferr_q;
    assign busy_out       = busy_q;
    assign err_cnt_out    = err_cnt_q;

endmodule

// File: tb/tb_parity_serial_rx.sv
`timescale 1ns/1ps
// Directed bench for parity_serial_rx: an even-parity and an odd-parity instance share stimulus.
module tb_parity_serial_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_en = 1'b0;
    logic serial = 1'b1;
    logic clr_cnt = 1'b0;

    logic [7:0] e_data, o_data, e_cnt, o_cnt;
    logic e_p, e_valid, e_perr, e_ferr, e_busy;
    logic o_p, o_valid, o_perr, o_ferr, o_busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    parity_serial_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
        .clk_in(clk), .rst_n_in(rst_n), .bit_en_in(bit_en), .serial_in(serial),
        .clr_cnt_in(clr_cnt), .data_out(e_data), .p_out(e_p), .valid_out(e_valid),
        .parity_err_out(e_perr), .frame_err_out(e_ferr), .busy_out(e_busy),
        .err_cnt_out(e_cnt)
    );

    parity_serial_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
        .clk_in(clk), .rst_n_in(rst_n), .bit_en_in(bit_en), .serial_in(serial),
        .clr_cnt_in(clr_cnt), .data_out(o_data), .p_out(o_p), .valid_out(o_valid),
        .parity_err_out(o_perr), .frame_err_out(o_ferr), .busy_out(o_busy),
        .err_cnt_out(o_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then return 1ns after the rising edge that samples them.
    task automatic step(input logic en, input logic b);
        bit_en = en;
        serial = b;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Full frame with bit_en held high; reports how many valid pulses were seen and when.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              output int vcnt, output int vcyc);
        logic [10:0] bits;
        bits = {stp, p, d, 1'b0};
        vcnt = 0;
        vcyc = -1;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, bits[i]);
            if (e_valid === 1'b1) begin
                vcnt++;
                vcyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({e_data, e_p, e_valid, e_perr, e_ferr, e_busy, e_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_even: got %h want 0",
                     {e_data, e_p, e_valid, e_perr, e_ferr, e_busy, e_cnt});
        end
        n_checks++;
        if ({o_data, o_p, o_valid, o_perr, o_ferr, o_busy, o_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_odd: got %h want 0",
                     {o_data, o_p, o_valid, o_perr, o_ferr, o_busy, o_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_checks++;
        if (e_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b want 0", e_busy);
        end
    endtask

    task automatic test_clean();
        int vc, vt;
        step(1'b1, 1'b0);
        n_checks++;
        if (e_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_busy_start: got %b want 1", e_busy);
        end
        // Start bit already sent; finish 0xA5 by hand to keep the busy check above.
        vc = 0;
        vt = 0;
        for (int i = 0; i < 8; i++) step(1'b1, (8'hA5 >> i) & 8'h01 ? 1'b1 : 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (e_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_valid: got %b want 1", e_valid);
        end
        n_checks++;
        if ({e_data, e_perr, e_ferr, e_busy} !== {8'hA5, 3'b000}) begin
            n_fail++;
            $display("FAIL clean_out: got data=%h perr=%b ferr=%b busy=%b want a5 0 0 0",
                     e_data, e_perr, e_ferr, e_busy);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if ({e_valid, e_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL clean_after: got valid=%b cnt=%0d want 0 0", e_valid, e_cnt);
        end
    endtask

    task automatic test_parity_err();
        int vc, vt;
        send_frame(8'h01, 1'b0, 1'b1, vc, vt);
        n_checks++;
        if ({e_valid, e_perr, e_p, e_cnt} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL perr_flag: got valid=%b perr=%b p=%b cnt=%0d want 1 1 0 0",
                     e_valid, e_perr, e_p, e_cnt);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if (e_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL perr_cnt1: got %0d want 1", e_cnt);
        end
        for (int f = 0; f < 299; f++) send_frame(8'h01, 1'b0, 1'b1, vc, vt);
        step(1'b1, 1'b1);
        n_checks++;
        if (e_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL perr_saturate: got %0d want 255", e_cnt);
        end
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        clr_cnt = 1'b0;
        n_checks++;
        if (e_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL perr_clear: got %0d want 0", e_cnt);
        end
        // Clear in the same cycle as a pending increment must win.
        send_frame(8'h01, 1'b0, 1'b1, vc, vt);
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        clr_cnt = 1'b0;
        step(1'b1, 1'b1);
        n_checks++;
        if (e_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_wins: got %0d want 0", e_cnt);
        end
    endtask

    task automatic test_framing();
        int vc, vt;
        send_frame(8'h3C, 1'b0, 1'b0, vc, vt);
        n_checks++;
        if ({vc[1:0], e_data, e_ferr, e_perr} !== {2'd1, 8'h3C, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL framing: got vcnt=%0d data=%h ferr=%b perr=%b want 1 3c 1 0",
                     vc, e_data, e_ferr, e_perr);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_checks++;
        if (e_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL framing_cnt: got %0d want 0", e_cnt);
        end
    endtask

    task automatic test_gapped();
        logic [10:0] bits;
        int t0, vc, vt;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        t0 = cyc;
        vc = 0;
        vt = -1;
        // Enable runs 1,0,0 continuously; each bit window is (0,0,1) with a glitch mid-window.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, bits[i]);
            if (e_valid === 1'b1) begin vc++; vt = cyc; end
            step(1'b0, ~bits[i]);
            if (e_valid === 1'b1) begin vc++; vt = cyc; end
            step(1'b1, bits[i]);
            if (e_valid === 1'b1) begin vc++; vt = cyc; end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            if (e_valid === 1'b1) begin vc++; vt = cyc; end
        end
        n_checks++;
        if (vc != 1 || (vt - t0) != 33) begin
            n_fail++;
            $display("FAIL gapped_valid: got count=%0d delay=%0d want 1 33", vc, vt - t0);
        end
        n_checks++;
        if ({e_data, e_perr, e_ferr} !== {8'h5A, 2'b00}) begin
            n_fail++;
            $display("FAIL gapped_data: got data=%h perr=%b ferr=%b want 5a 0 0",
                     e_data, e_perr, e_ferr);
        end
        step(1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int vc1, vt1, vc2, vt2;
        send_frame(8'h12, 1'b0, 1'b1, vc1, vt1);
        n_checks++;
        if ({e_data, e_perr, e_ferr} !== {8'h12, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_first: got data=%h perr=%b ferr=%b want 12 0 0",
                     e_data, e_perr, e_ferr);
        end
        send_frame(8'h34, 1'b1, 1'b1, vc2, vt2);
        n_checks++;
        if ({e_data, e_perr, e_ferr} !== {8'h34, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_second: got data=%h perr=%b ferr=%b want 34 0 0",
                     e_data, e_perr, e_ferr);
        end
        n_checks++;
        if (vc1 != 1 || vc2 != 1 || (vt2 - vt1) != 11) begin
            n_fail++;
            $display("FAIL b2b_spacing: got counts=%0d,%0d gap=%0d want 1,1 11",
                     vc1, vc2, vt2 - vt1);
        end
        step(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int vc, vt;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        n_checks++;
        if (e_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy: got %b want 1", e_busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({e_data, e_p, e_valid, e_perr, e_ferr, e_busy, e_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0",
                     {e_data, e_p, e_valid, e_perr, e_ferr, e_busy, e_cnt});
        end
        serial = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hFF, 1'b0, 1'b1, vc, vt);
        n_checks++;
        if (vc != 1 || {e_data, e_perr, e_ferr} !== {8'hFF, 2'b00}) begin
            n_fail++;
            $display("FAIL midrst_frame: got vcnt=%0d data=%h perr=%b ferr=%b want 1 ff 0 0",
                     vc, e_data, e_perr, e_ferr);
        end
        step(1'b1, 1'b1);
    endtask

    task automatic test_odd_parity();
        int vc, vt;
        send_frame(8'h00, 1'b1, 1'b1, vc, vt);
        n_checks++;
        if ({o_valid, o_data, o_p, o_perr} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL odd_ok: got valid=%b data=%h p=%b perr=%b want 1 00 1 0",
                     o_valid, o_data, o_p, o_perr);
        end
        n_checks++;
        if (e_perr !== 1'b1) begin
            n_fail++;
            $display("FAIL even_of_odd_frame: got perr=%b want 1", e_perr);
        end
        send_frame(8'h00, 1'b0, 1'b1, vc, vt);
        n_checks++;
        if ({o_valid, o_perr} !== 2'b11) begin
            n_fail++;
            $display("FAIL odd_err: got valid=%b perr=%b want 1 1", o_valid, o_perr);
        end
        step(1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_parity_err();
        test_framing();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_odd_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_serial_rx.md
# parity_serial_rx

Serial frame receiver and deserializer that sits directly upstream of the parity checking stage. It accepts one line bit per qualified clock and frames it as start, DATA_W data bits (LSB first), one parity bit and one stop bit. It delivers the recovered data word with the received parity bit, a computed parity-error flag and a framing-error flag. It also maintains a saturating count of parity errors for status readout.

## Interface
- DATA_W, 8: data bits per frame; legal range 1..16.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- bit_en_in  input  1  qualifies serial_in; one line bit is consumed per cycle in which this input is high.
- serial_in  input  1  serial line bit; the line idles high.
- clr_cnt_in  input  1  synchronous clear of err_cnt_out.
- data_out  output  DATA_W  last received data word, held until the next frame completes.
- p_out  output  1  received parity bit of the last frame, held.
- valid_out  output  1  one-cycle pulse marking a completed frame.
- parity_err_out  output  1  parity mismatch for the last frame; held with data_out.
- frame_err_out  output  1  stop bit sampled low for the last frame; held with data_out.
- busy_out  output  1  high whenever the FSM is not in IDLE.
- err_cnt_out  output  8  saturating count of frames with parity_err_out set.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. States advance only on cycles with bit_en_in=1; cycles with bit_en_in=0 hold all state.
- IDLE:
  - serial_in=1 keeps the FSM in IDLE.
  - serial_in=0 is a start bit: clear the shift register and bit counter, then go to DATA.
- DATA:
  - Shift serial_in into bit position cnt (LSB first) and increment cnt.
  - When cnt reaches DATA_W-1 on a sampled bit, go to PARITY.
- PARITY: capture serial_in as the parity bit, then go to STOP.
- STOP, on a sampled bit:
  - Load data_out and p_out.
  - parity_err_out = (^data) ^ p ^ PARITY_ODD.
  - frame_err_out = ~serial_in.
  - Pulse valid_out and return to IDLE.
- A frame with a framing error is still delivered with valid_out. Both error flags may be set at once.
- err_cnt_out:
  - Increments by 1 on each valid_out pulse with parity_err_out=1 and saturates at 255.
  - clr_cnt_in=1 zeroes the counter. If a clear and an increment fall in the same cycle, the clear wins and the result is 0.
- A new start bit is accepted on the first bit_en_in after STOP; no idle gap between frames is required.
- Reset asserted mid-frame discards the partial frame; the FSM restarts in IDLE.

## Timing
- Reset values of all outputs:
  - data_out=0, p_out=0, valid_out=0, parity_err_out=0, frame_err_out=0, busy_out=0, err_cnt_out=0.
  - Internal state: FSM=IDLE, cnt=0, shift register=0.
- All outputs are registered.
- valid_out is high for exactly the one cycle after the edge that samples the stop bit. data_out and both error flags update on that same edge.
- err_cnt_out reflects a parity error one cycle after valid_out, i.e. it is updated from the registered flag.
- busy_out goes high the cycle after the start bit is sampled. It goes low the cycle after the stop bit is sampled, in the same cycle valid_out is high.
- Frame length is DATA_W+3 sampled bits. With bit_en_in continuously high, the minimum frame period is DATA_W+3 cycles.
- valid_out never asserts on two consecutive cycles.

## Test plan
- Clean frame, even parity, bit_en_in tied high. Send start 0, data 0xA5 LSB first, parity 0, stop 1 -> single valid_out pulse; data_out=0xA5, parity_err_out=0, frame_err_out=0, err_cnt_out=0.
- Parity error. Data 0x01 with parity 0 -> valid_out pulse, parity_err_out=1, and err_cnt_out=1 one cycle later. Repeat for 300 such frames -> err_cnt_out saturates at 255; then assert clr_cnt_in -> err_cnt_out=0.
- Framing error. Data 0x3C, parity 0, stop 0 -> valid_out pulse, data_out=0x3C, frame_err_out=1, parity_err_out=0.
- Gapped enables. Toggle bit_en_in 1,0,0 repeatedly while sending 0x5A. serial_in changes on disabled cycles must be ignored -> data_out=0x5A, and valid_out appears once, 33 cycles after the start bit.
- Back-to-back frames. Send 0x12 then 0x34 with no idle bit between them -> two valid_out pulses exactly 11 cycles apart, both frames error-free.
- Reset mid-frame. Assert rst_n_in low after 4 data bits -> all outputs return to reset values immediately. A full frame 0xFF, parity 0, sent after release -> data_out=0xFF, no errors.
- Odd-parity build, PARITY_ODD=1. Data 0x00 with parity 1 -> parity_err_out=0; the same data with parity 0 -> parity_err_out=1.
